// File: rtl/pwm_pkg.sv
// Shared defaults and helpers for the multi-channel PWM block.
package pwm_pkg;
  localparam int PWM_CHANNELS    = 4;
  localparam int PWM_WIDTH       = 8;
  localparam int PWM_PRESC_WIDTH = 4;

  typedef logic [PWM_WIDTH-1:0] duty_t;

  // Phase offset of channel ch, spreading channels evenly over one period.
  function automatic int unsigned stagger_offset(input int unsigned ch,
                                                 input int unsigned width,
                                                 input int unsigned channels);
    return (ch << width) / channels;
  endfunction
endpackage

// File: rtl/pwm_multi_channel_if.sv
// Control/status bundle between the duty computation logic and the PWM block.
interface pwm_multi_channel_if
  import pwm_pkg::*;
#(
  parameter int CHANNELS    = PWM_CHANNELS,
  parameter int WIDTH       = PWM_WIDTH,
  parameter int PRESC_WIDTH = PWM_PRESC_WIDTH
);
  logic                             enable;
  logic [PRESC_WIDTH-1:0]           presc;
  logic [CHANNELS-1:0][WIDTH-1:0]   duty_in;
  logic [CHANNELS-1:0]              duty_wr;
  logic                             commit;
  logic [CHANNELS-1:0]              pwm_out;
  logic                             period_start;
  logic                             commit_pending;

  modport master (
    output enable, presc, duty_in, duty_wr, commit,
    input  pwm_out, period_start, commit_pending
  );

  modport slave (
    input  enable, presc, duty_in, duty_wr, commit,
    output pwm_out, period_start, commit_pending
  );
endinterface

// File: rtl/pwm_prescaler.sv
// Tick generator: one tick every presc+1 clocks while enabled, idle at 0 otherwise.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int PRESC_WIDTH = PWM_PRESC_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [PRESC_WIDTH-1:0] presc,
  output logic                   tick
);
  logic [PRESC_WIDTH-1:0] presc_cnt_q, presc_cnt_d;

  // >= lets a reduced presc take effect without waiting for a counter wrap.
  always_comb begin
    tick        = 1'b0;
    presc_cnt_d = '0;
    if (enable) begin
      if (presc_cnt_q >= presc) tick = 1'b1;
      else                      presc_cnt_d = presc_cnt_q + PRESC_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) presc_cnt_q <= '0;
    else       presc_cnt_q <= presc_cnt_d;
  end
endmodule

// File: rtl/pwm_multi_channel.sv
// N-channel PWM with prescaler, double-buffered duty committed at period
// boundaries, optional per-channel phase stagger and global enable.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int CHANNELS    = PWM_CHANNELS,
  parameter int WIDTH       = PWM_WIDTH,
  parameter int PRESC_WIDTH = PWM_PRESC_WIDTH,
  parameter int STAGGER     = 1
) (
  input  logic          clk,
  input  logic          reset,
  pwm_multi_channel_if.slave bus
);
  typedef logic [CHANNELS-1:0][WIDTH-1:0] duty_vec_t;

  if (CHANNELS < 1 || (STAGGER != 0 && (CHANNELS & (CHANNELS - 1)) != 0)) begin : g_bad_cfg
    $error("pwm_multi_channel: CHANNELS must be a power of two when STAGGER=1");
  end

  logic                tick, boundary;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  duty_vec_t           pending_q, pending_d, active_q, active_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                period_start_q, period_start_d;
  logic                commit_pending_q, commit_pending_d;

  pwm_prescaler #(.PRESC_WIDTH(PRESC_WIDTH)) u_presc (
    .clk    (clk),
    .reset  (reset),
    .enable (bus.enable),
    .presc  (bus.presc),
    .tick   (tick)
  );

  // tick is already gated by enable, so boundary never fires while disabled.
  assign boundary = tick && (cnt_q == {WIDTH{1'b1}});

  always_comb begin
    cnt_d = '0;
    if (bus.enable) cnt_d = tick ? cnt_q + WIDTH'(1) : cnt_q;

    pending_d = pending_q;
    for (int i = 0; i < CHANNELS; i++)
      if (bus.duty_wr[i]) pending_d[i] = bus.duty_in[i];

    // Transfers use pending_q, so a same-cycle write stays pending.
    active_d         = active_q;
    commit_pending_d = commit_pending_q;
    if (!bus.enable) begin
      commit_pending_d = 1'b0;
      if (bus.commit || commit_pending_q) active_d = pending_q;
    end else if (boundary && (bus.commit || commit_pending_q)) begin
      active_d         = pending_q;
      commit_pending_d = 1'b0;
    end else if (bus.commit) begin
      commit_pending_d = 1'b1;
    end

    period_start_d = boundary;
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    localparam logic [WIDTH-1:0] OFFSET =
      (STAGGER != 0) ? WIDTH'(stagger_offset(g, WIDTH, CHANNELS)) : '0;
    logic [WIDTH-1:0] ch_cnt;
    assign ch_cnt   = cnt_q + OFFSET;
    assign pwm_d[g] = bus.enable & (ch_cnt < active_q[g]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q            <= '0;
      pending_q        <= '0;
      active_q         <= '0;
      pwm_q            <= '0;
      period_start_q   <= 1'b0;
      commit_pending_q <= 1'b0;
    end else begin
      cnt_q            <= cnt_d;
      pending_q        <= pending_d;
      active_q         <= active_d;
      pwm_q            <= pwm_d;
      period_start_q   <= period_start_d;
      commit_pending_q <= commit_pending_d;
    end
  end

  assign bus.pwm_out        = pwm_q;
  assign bus.period_start   = period_start_q;
  assign bus.commit_pending = commit_pending_q;
endmodule

// File: tb/tb_pwm_multi_channel.sv
// Scoreboard bench: stimulus queues expected per-period and point results,
// a negedge monitor measures the outputs and compares.
module tb_pwm_multi_channel;
  import pwm_pkg::*;

  localparam int CH = 4, W = 8, PW = 4;
  localparam int NONE = 65535, DC = 65534;

  typedef logic [8*16-1:0]      tag_t;
  typedef logic [CH-1:0][15:0]  v16_t;
  typedef logic [CH-1:0][W-1:0] dvec_t;

  typedef struct packed {
    tag_t        name;
    logic [15:0] len;
    v16_t        high, rise, rise2;
  } per_exp_t;

  typedef struct packed {
    tag_t          name;
    logic [CH-1:0] pwm;
    logic          cp;
    logic          ps;
  } pt_exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pwm_multi_channel_if #(.CHANNELS(CH), .WIDTH(W), .PRESC_WIDTH(PW)) bus ();
  pwm_multi_channel_if #(.CHANNELS(CH), .WIDTH(W), .PRESC_WIDTH(PW)) bus2 ();

  assign bus2.enable  = bus.enable;
  assign bus2.presc   = bus.presc;
  assign bus2.duty_in = bus.duty_in;
  assign bus2.duty_wr = bus.duty_wr;
  assign bus2.commit  = bus.commit;

  pwm_multi_channel #(.CHANNELS(CH), .WIDTH(W), .PRESC_WIDTH(PW), .STAGGER(1)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  pwm_multi_channel #(.CHANNELS(CH), .WIDTH(W), .PRESC_WIDTH(PW), .STAGGER(0)) dut_aligned (
    .clk(clk), .reset(reset), .bus(bus2));

  per_exp_t pq[$];
  pt_exp_t  ptq[$];
  int tests = 0, fails = 0;

  task automatic chk(input tag_t n, input string what, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %0s %0s: got %0d expected %0d", n, what, act, exp);
    end
  endtask

  function automatic v16_t v4(input int a0, input int a1, input int a2, input int a3);
    v16_t r;
    r[0] = a0[15:0]; r[1] = a1[15:0]; r[2] = a2[15:0]; r[3] = a3[15:0];
    return r;
  endfunction

  function automatic dvec_t dv(input int a0, input int a1, input int a2, input int a3);
    dvec_t r;
    r[0] = duty_t'(a0); r[1] = duty_t'(a1); r[2] = duty_t'(a2); r[3] = duty_t'(a3);
    return r;
  endfunction

  // Monitor: point checks at the next negedge, period stats at each period_start.
  int hi[CH], hi2[CH], ri[CH], ri2[CH];
  int pos = 0;
  logic [CH-1:0] prev = '0, prev2 = '0;
  pt_exp_t  pt;
  per_exp_t pe;

  always @(negedge clk) begin
    if (ptq.size() > 0) begin
      pt = ptq.pop_front();
      chk(pt.name, "pwm_out", int'(bus.pwm_out), int'(pt.pwm));
      chk(pt.name, "commit_pending", int'(bus.commit_pending), int'(pt.cp));
      chk(pt.name, "period_start", int'(bus.period_start), int'(pt.ps));
    end
    if (bus.period_start) begin
      if (pq.size() > 0) begin
        pe = pq.pop_front();
        chk(pe.name, "period_len", pos, int'(pe.len));
        for (int i = 0; i < CH; i++) begin
          chk(pe.name, $sformatf("high[%0d]", i), hi[i], int'(pe.high[i]));
          chk(pe.name, $sformatf("high_aligned[%0d]", i), hi2[i], int'(pe.high[i]));
          if (int'(pe.rise[i]) != DC)
            chk(pe.name, $sformatf("rise[%0d]", i), ri[i], int'(pe.rise[i]));
          if (int'(pe.rise2[i]) != DC)
            chk(pe.name, $sformatf("rise_aligned[%0d]", i), ri2[i], int'(pe.rise2[i]));
        end
      end
      pos = 0;
      for (int i = 0; i < CH; i++) begin
        hi[i] = 0; hi2[i] = 0; ri[i] = NONE; ri2[i] = NONE;
      end
    end
    for (int i = 0; i < CH; i++) begin
      if (bus.pwm_out[i])  hi[i]++;
      if (bus2.pwm_out[i]) hi2[i]++;
      if (bus.pwm_out[i]  && !prev[i]  && ri[i]  == NONE) ri[i]  = pos;
      if (bus2.pwm_out[i] && !prev2[i] && ri2[i] == NONE) ri2[i] = pos;
    end
    prev  = bus.pwm_out;
    prev2 = bus2.pwm_out;
    pos++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_ps();
    int k = 0;
    do begin step(); k++; end while (!bus.period_start && k < 4000);
    if (!bus.period_start) begin
      tests++; fails++;
      $display("FAIL period_start timeout: got none expected pulse within 4000 clk");
    end
  endtask

  task automatic wr(input logic [CH-1:0] m, input dvec_t d, input logic c);
    bus.duty_wr = m; bus.duty_in = d; bus.commit = c;
    step();
    bus.duty_wr = '0; bus.commit = 1'b0;
  endtask

  task automatic push_pt(input tag_t n, input logic [CH-1:0] p, input logic cp, input logic ps);
    pt_exp_t e;
    e.name = n; e.pwm = p; e.cp = cp; e.ps = ps;
    ptq.push_back(e);
  endtask

  task automatic push_per(input tag_t n, input int len, input v16_t h, input v16_t r, input v16_t r2);
    per_exp_t e;
    e.name = n; e.len = len[15:0]; e.high = h; e.rise = r; e.rise2 = r2;
    pq.push_back(e);
  endtask

  initial begin
    reset = 1'b1;
    bus.enable = 1'b0; bus.presc = '0; bus.duty_in = '0; bus.duty_wr = '0; bus.commit = 1'b0;
    push_pt("reset", 4'b0000, 1'b0, 1'b0);
    step(); step();
    reset = 1'b0;
    step();

    // Write while disabled, commit applies immediately without a pending flag.
    wr(4'b0001, dv(64, 0, 0, 0), 1'b0);
    push_pt("en0_commit", 4'b0000, 1'b0, 1'b0);
    wr(4'b0000, dv(64, 0, 0, 0), 1'b1);
    bus.enable = 1'b1;
    wait_ps();
    push_per("duty64", 256, v4(64, 0, 0, 0), v4(1, NONE, NONE, NONE), v4(1, NONE, NONE, NONE));
    wait_ps();

    // Duty 0 and full-scale duty; commit mid-period waits for the boundary.
    push_pt("commit_mid", 4'b0001, 1'b1, 1'b0);
    wr(4'b0110, dv(64, 0, 255, 0), 1'b1);
    wait_ps();
    push_pt("after_bnd", 4'b0101, 1'b0, 1'b0);
    wait_ps();
    push_per("duty0_255", 256, v4(64, 0, 255, 0), v4(1, NONE, 129, NONE), v4(1, NONE, 1, NONE));
    wait_ps();

    // Equal duty on all channels exposes the stagger offsets.
    wr(4'b1111, dv(64, 64, 64, 64), 1'b1);
    wait_ps(); wait_ps();
    push_per("stagger", 256, v4(64, 64, 64, 64), v4(1, 193, 129, 65), v4(1, 1, 1, 1));
    wait_ps();

    // Commit at cnt=100: this period keeps the old duty, next one gets 200.
    steps(100);
    push_pt("commit_pend", 4'b1000, 1'b1, 1'b0);
    push_per("old_duty", 256, v4(64, 64, 64, 64), v4(1, 193, 129, 65), v4(1, 1, 1, 1));
    wr(4'b0001, dv(200, 64, 64, 64), 1'b1);
    wait_ps();
    push_pt("commit_done", 4'b0001, 1'b0, 1'b0);
    push_per("new_duty200", 256, v4(200, 64, 64, 64), v4(1, 193, 129, 65), v4(1, 1, 1, 1));
    wait_ps();

    // Write on the boundary cycle without commit leaves active untouched.
    steps(255);
    push_pt("bnd_wr", 4'b0010, 1'b0, 1'b1);
    wr(4'b0001, dv(10, 64, 64, 64), 1'b0);
    push_per("bnd_wr_nocommit", 256, v4(200, 64, 64, 64), v4(1, 193, 129, 65), v4(1, 1, 1, 1));
    wait_ps();

    // Write plus commit on the boundary: active takes the pre-write pending value.
    steps(255);
    push_pt("bnd_commit", 4'b0010, 1'b0, 1'b1);
    wr(4'b0001, dv(77, 64, 64, 64), 1'b1);
    push_per("bnd_wr_commit", 256, v4(10, 64, 64, 64), v4(1, 193, 129, 65), v4(1, 1, 1, 1));
    wait_ps();

    // Prescaler 3: 1024-clk period, each tick of duty is 4 clk.
    bus.presc = 4'd3;
    wr(4'b0001, dv(128, 64, 64, 64), 1'b1);
    wait_ps(); wait_ps();
    push_per("presc3", 1024, v4(512, 256, 256, 256), v4(DC, DC, DC, DC), v4(DC, DC, DC, DC));
    wait_ps();

    // Asynchronous reset mid-period at cnt=150.
    bus.presc = '0;
    wr(4'b0001, dv(200, 64, 64, 64), 1'b1);
    wait_ps(); wait_ps();
    steps(150);
    push_pt("pre_reset", 4'b0101, 1'b0, 1'b0);
    step();
    @(posedge clk);
    #1;
    reset = 1'b1;
    push_pt("async_reset", 4'b0000, 1'b0, 1'b0);
    step(); step();
    reset = 1'b0;
    steps(10);
    push_pt("post_reset", 4'b0000, 1'b0, 1'b0);
    step();
    wait_ps();
    push_per("post_reset_idle", 256, v4(0, 0, 0, 0), v4(NONE, NONE, NONE, NONE), v4(NONE, NONE, NONE, NONE));
    wait_ps();

    // Commit while disabled takes effect on the next clock.
    bus.enable = 1'b0;
    wr(4'b0001, dv(32, 0, 0, 0), 1'b0);
    push_pt("dis_commit", 4'b0000, 1'b0, 1'b0);
    wr(4'b0000, dv(32, 0, 0, 0), 1'b1);
    bus.enable = 1'b1;
    wait_ps();
    push_per("dis_commit_apply", 256, v4(32, 0, 0, 0), v4(1, NONE, NONE, NONE), v4(1, NONE, NONE, NONE));
    wait_ps();

    step(); step();
    while (pq.size() > 0) begin
      pe = pq.pop_front();
      tests++; fails++;
      $display("FAIL %0s never_checked: got no period expected one", pe.name);
    end
    while (ptq.size() > 0) begin
      pt = ptq.pop_front();
      tests++; fails++;
      $display("FAIL %0s never_checked: got no sample expected one", pt.name);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
